// File: rtl/systolic_pkg.sv
// Shared types and constants for the 4x4 systolic array sequencer.
package systolic_pkg;

    localparam int N           = 4;
    localparam int DW          = 8;
    localparam int FEED_CYCLES = 3 * N - 2;
    localparam int IDX_W       = $clog2(N);
    localparam int CNT_W       = 4;

    typedef logic [DW-1:0] elem_t;
    // Element j of a row sits at bits [j*DW +: DW].
    typedef elem_t [N-1:0] row_t;
    typedef row_t  [N-1:0] mat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_SETTLE,
        ST_DRAIN,
        ST_OUT
    } state_t;

endpackage

// File: rtl/systolic_skew.sv
// Diagonal skew generator: during FEED step t, row k carries A[k][t-k] and
// column j carries B[t-j][j]. Lanes outside their window carry 0.
module systolic_skew
    import systolic_pkg::*;
(
    input  mat_t             a_buf,
    input  mat_t             b_buf,
    input  logic             feed_en,
    input  logic [CNT_W-1:0] t,
    output row_t             row_out,
    output row_t             col_out
);

    logic [CNT_W-1:0] off;

    // Select the operand element each lane needs at step t.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a value held (no latch).
        row_out = '0;
        col_out = '0;
        off     = '0;
        for (int k = 0; k < N; k++) begin
            off = t - CNT_W'(k);
            if (feed_en && (t >= CNT_W'(k)) && (off < CNT_W'(N))) begin
                row_out[IDX_W'(k)] = a_buf[IDX_W'(k)][off[IDX_W-1:0]];
                col_out[IDX_W'(k)] = b_buf[off[IDX_W-1:0]][IDX_W'(k)];
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 4x4 output-stationary PE array: loads A and B, feeds the
// skewed streams, drains results through OutputSign and returns C row by row.
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN adds a saturating 16-bit
// result-stall counter on port perf_stall_cnt.
module systolic_ctrl #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int DRAIN_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*DW-1:0] s_a_row,
    input  logic [N*DW-1:0] s_b_row,
    output logic [DW-1:0]   arr_row_0,
    output logic [DW-1:0]   arr_row_1,
    output logic [DW-1:0]   arr_row_2,
    output logic [DW-1:0]   arr_row_3,
    output logic [DW-1:0]   arr_col_0,
    output logic [DW-1:0]   arr_col_1,
    output logic [DW-1:0]   arr_col_2,
    output logic [DW-1:0]   arr_col_3,
    output logic            arr_output_sign,
    input  logic [DW-1:0]   arr_out_0,
    input  logic [DW-1:0]   arr_out_1,
    input  logic [DW-1:0]   arr_out_2,
    input  logic [DW-1:0]   arr_out_3,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N*DW-1:0] m_c_row,
    output logic            busy
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_stall_cnt
`endif
);

    import systolic_pkg::*;

    if (N != 4) begin : g_bad_n
        $error("systolic_ctrl: only N=4 is supported");
    end
    if (DW != systolic_pkg::DW) begin : g_bad_dw
        $error("systolic_ctrl: DW must match the array datapath width");
    end
    if ((DRAIN_LAT < 1) || (DRAIN_LAT > 8)) begin : g_bad_lat
        $error("systolic_ctrl: DRAIN_LAT must be in 1..8");
    end

    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(FEED_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_SETL  = CNT_W'(DRAIN_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(N + DRAIN_LAT - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    mat_t             a_buf, b_buf, c_buf;
    row_t             skew_row, skew_col;
    row_t             arr_row_q, arr_col_q;
    row_t             arr_out;
    logic             s_hs, m_hs;
    logic [CNT_W-1:0] cap_pos;
    logic [IDX_W-1:0] cap_col;

    assign s_hs    = s_valid && s_ready;
    assign m_valid = (state == ST_OUT);
    assign m_hs    = m_valid && m_ready;
    assign busy    = (state != ST_IDLE);
    assign m_c_row = c_buf[cnt[IDX_W-1:0]];
    assign arr_out = {arr_out_3, arr_out_2, arr_out_1, arr_out_0};

    // Drain step cnt holds the value that left column N-1-(cnt-DRAIN_LAT).
    assign cap_pos = LAST_DRAIN - cnt;
    assign cap_col = cap_pos[IDX_W-1:0];

    assign arr_row_0 = arr_row_q[0];
    assign arr_row_1 = arr_row_q[1];
    assign arr_row_2 = arr_row_q[2];
    assign arr_row_3 = arr_row_q[3];
    assign arr_col_0 = arr_col_q[0];
    assign arr_col_1 = arr_col_q[1];
    assign arr_col_2 = arr_col_q[2];
    assign arr_col_3 = arr_col_q[3];

    // Phase sequencing; cnt is the beat, feed step, settle or drain index.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                if (s_hs) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (s_hs) begin
                    if (cnt == LAST_ROW) begin
                        state_d = ST_FEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            ST_FEED: begin
                if (cnt == LAST_FEED) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt == LAST_SETL) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    state_d = ST_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (m_hs) begin
                    if (cnt == LAST_ROW) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and index register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Load ready is registered so it reads 0 throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
        end
    end

    // Operand buffers: beat i of a job writes row i of A and B.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these buffers are plain registers with a defined reset value, not a RAM macro.
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (s_hs) begin
            a_buf[cnt[IDX_W-1:0]] <= s_a_row;
            b_buf[cnt[IDX_W-1:0]] <= s_b_row;
        end
    end

    // Result capture as the array shifts its accumulators out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_buf <= '0;
        end else if ((state == ST_DRAIN) && (cnt >= CNT_W'(DRAIN_LAT))) begin
            for (int k = 0; k < N; k++) begin
                c_buf[IDX_W'(k)][cap_col] <= arr_out[IDX_W'(k)];
            end
        end
    end

    systolic_skew u_skew (
        .a_buf   (a_buf),
        .b_buf   (b_buf),
        .feed_en (state_d == ST_FEED),
        .t       (cnt_d),
        .row_out (skew_row),
        .col_out (skew_col)
    );

    // Array-facing outputs, registered from next-state so they line up with the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_row_q       <= '0;
            arr_col_q       <= '0;
            arr_output_sign <= 1'b0;
        end else begin
            arr_row_q       <= skew_row;
            arr_col_q       <= skew_col;
            arr_output_sign <= (state_d == ST_DRAIN) && (cnt_d < CNT_W'(N));
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Saturating count of result cycles lost to m_ready back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if ((state == ST_IDLE) && s_hs) begin
            perf_stall_cnt <= '0;
        end else if (m_valid && !m_ready && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
